// File: rtl/ion_channel_current.sv
// Hodgkin-Huxley single-gate ionic current: I = G_MAX * x^GATE_POW * (V - E_REV),
// evaluated in signed Q(W-FRAC).FRAC on one shared saturating multiplier.
module ion_channel_current #(
  parameter int W        = 16,
  parameter int FRAC     = 8,
  parameter int GATE_POW = 4,
  parameter int G_MAX    = 9216,
  parameter int E_REV    = -3072
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [W-1:0] V,
  input  logic signed [W-1:0] gate,
  output logic                busy,
  output logic                done,
  output logic signed [W-1:0] I_ion
);

  typedef enum logic [1:0] {S_IDLE, S_POW, S_COND, S_DRIVE} state_t;

  localparam int CW = 4;
  localparam logic signed [W-1:0]   ONE    = W'(1 << FRAC);
  localparam logic signed [W-1:0]   GMAX_W = W'(G_MAX);
  localparam logic signed [W:0]     EREV_X = (W+1)'(E_REV);
  localparam logic signed [W-1:0]   SMAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]   SMIN   = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [2*W-1:0] PMAX   = (2*W)'(SMAX);
  localparam logic signed [2*W-1:0] PMIN   = (2*W)'(SMIN);
  // Remaining POW iterations after the first one, counted down to zero.
  localparam logic [CW-1:0] CNT_INIT = CW'((GATE_POW > 1) ? GATE_POW - 2 : 0);

  state_t                state_q, state_d;
  logic signed [W-1:0]   acc_q, acc_d;
  logic signed [W-1:0]   v_q, v_d;
  logic signed [W-1:0]   xc_q, xc_d;
  logic signed [W-1:0]   ion_q, ion_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done_q, done_d;

  logic signed [W-1:0]   gate_cl;
  logic signed [W:0]     vdiff;
  logic signed [W-1:0]   vdiff_sat;
  logic signed [W-1:0]   mul_a, mul_b, mul_y;
  logic signed [2*W-1:0] prod, prod_sh;

  always_comb begin
    gate_cl = gate;
    if (gate[W-1])      gate_cl = '0;
    else if (gate > ONE) gate_cl = ONE;
  end

  // Driving force: one extra bit so the subtraction itself cannot wrap.
  always_comb begin
    vdiff     = {v_q[W-1], v_q} - EREV_X;
    vdiff_sat = vdiff[W-1:0];
    if (vdiff[W] != vdiff[W-1]) vdiff_sat = vdiff[W] ? SMIN : SMAX;
  end

  always_comb begin
    mul_a = acc_q;
    mul_b = xc_q;
    case (state_q)
      S_COND:  begin mul_a = GMAX_W; mul_b = acc_q;     end
      S_DRIVE: begin mul_a = acc_q;  mul_b = vdiff_sat; end
      default: ;
    endcase
    prod    = (2*W)'(mul_a) * (2*W)'(mul_b);
    prod_sh = prod >>> FRAC;
    if (prod_sh > PMAX)      mul_y = SMAX;
    else if (prod_sh < PMIN) mul_y = SMIN;
    else                     mul_y = prod_sh[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    v_d     = v_q;
    xc_d    = xc_q;
    ion_d   = ion_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        v_d     = V;
        xc_d    = gate_cl;
        acc_d   = gate_cl;
        cnt_d   = CNT_INIT;
        state_d = (GATE_POW > 1) ? S_POW : S_COND;
      end
      S_POW: begin
        acc_d = mul_y;
        if (cnt_q == '0) state_d = S_COND;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_COND: begin
        acc_d   = mul_y;
        state_d = S_DRIVE;
      end
      S_DRIVE: begin
        ion_d   = mul_y;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      v_q     <= '0;
      xc_q    <= '0;
      ion_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      xc_q    <= xc_d;
      ion_q   <= ion_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign I_ion = ion_q;

endmodule

// File: tb/tb_ion_channel_current.sv
// Bench for ion_channel_current: directed table, hand sequences and random
// vectors against an arithmetic model, on a GATE_POW=4 and a GATE_POW=1 instance.
module tb_ion_channel_current;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic signed [15:0] V = '0, gate = '0;
  logic busy0, done0, busy1, done1;
  logic signed [15:0] I0, I1;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  ion_channel_current dut0 (
    .clk(clk), .rst(rst), .start(start0), .V(V), .gate(gate),
    .busy(busy0), .done(done0), .I_ion(I0)
  );

  ion_channel_current #(.GATE_POW(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .V(V), .gate(gate),
    .busy(busy1), .done(done1), .I_ion(I1)
  );

  typedef struct {
    logic signed [15:0] v;
    logic signed [15:0] g;
    logic signed [15:0] exp_i;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Q8 multiply: floor(a*b/256), clipped to the 16-bit signed range.
  function automatic longint qm(input longint a, input longint b);
    longint p, q;
    p = a * b;
    q = (p >= 0) ? p / 256 : -((-p + 255) / 256);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  function automatic longint model(input int pw, input longint v, input longint g);
    longint x, acc, d;
    x = (g < 0) ? 0 : ((g > 256) ? 256 : g);
    acc = x;
    for (int i = 1; i < pw; i++) acc = qm(acc, x);
    acc = qm(9216, acc);
    d = v + 3072;
    if (d > 32767)  d = 32767;
    if (d < -32768) d = -32768;
    return qm(acc, d);
  endfunction

  // Pulses start for one edge, scrambles the inputs right after capture, then
  // counts edges until done (bounded) and how many of them had busy high.
  task automatic run(input bit which, input logic signed [15:0] v, input logic signed [15:0] g,
                     output int lat, output int bc, output logic signed [15:0] res);
    @(negedge clk);
    V = v; gate = g;
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    V = 16'($urandom); gate = 16'($urandom);
    lat = -1; bc = 0; res = '0;
    for (int j = 0; j < 20; j++) begin
      if (which ? done1 : done0) begin
        lat = j;
        res = which ? I1 : I0;
        break;
      end
      if (which ? busy1 : busy0) bc++;
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t tbl[5];
    int lat, bc;
    logic signed [15:0] res;
    logic signed [15:0] hv[26], hg[26];
    int ndone;

    tbl[0] = '{-16'sd2560,  16'sd128,   16'sd1152};
    tbl[1] = '{-16'sd5120,  16'sd128,  -16'sd4608};
    tbl[2] = '{ 16'sd0,     16'sd300,   16'sd32767};
    tbl[3] = '{-16'sd2560, -16'sd5,     16'sd0};
    tbl[4] = '{-16'sd3072,  16'sd128,   16'sd0};

    #12;
    chk("reset_busy0", busy0, 0);
    chk("reset_done0", done0, 0);
    chk("reset_I0", I0, 0);
    chk("reset_busy1", busy1, 0);
    chk("reset_done1", done1, 0);
    chk("reset_I1", I1, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run(1'b0, tbl[i].v, tbl[i].g, lat, bc, res);
      chk($sformatf("tbl%0d_I", i), res, tbl[i].exp_i);
      chk($sformatf("tbl%0d_lat", i), lat, 5);
      chk($sformatf("tbl%0d_busy_cycles", i), bc, 5);
    end

    // done is a single-cycle pulse and I_ion holds afterwards.
    run(1'b0, tbl[0].v, tbl[0].g, lat, bc, res);
    @(negedge clk);
    chk("done_one_cycle", done0, 0);
    chk("I_held", I0, 1152);

    run(1'b1, -16'sd2560, 16'sd128, lat, bc, res);
    chk("p1_I", res, 9216);
    chk("p1_lat", lat, 2);
    chk("p1_busy_cycles", bc, 2);

    for (int i = 0; i < 30; i++) begin
      logic signed [15:0] rv, rg;
      rv = 16'($urandom);
      rg = 16'($urandom_range(460, 0) - 60);
      run(1'b0, rv, rg, lat, bc, res);
      chk($sformatf("rnd%0d_I v=%0d g=%0d", i, rv, rg), res, model(4, rv, rg));
      chk($sformatf("rnd%0d_lat", i), lat, 5);
      if (i % 3 == 0) begin
        run(1'b1, rv, rg, lat, bc, res);
        chk($sformatf("rnd%0d_p1_I v=%0d g=%0d", i, rv, rg), res, model(1, rv, rg));
      end
    end

    // Start held high, inputs changing every cycle. A start seen in the done
    // cycle is taken on the edge that ends it, so accepted edges are 6 apart.
    @(negedge clk);
    ndone = 0;
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      if (c > 0) begin
        if (c % 6 == 0) begin
          chk($sformatf("hold_done_c%0d", c), done0, 1);
          chk($sformatf("hold_I_c%0d", c), I0, model(4, hv[c-6], hg[c-6]));
        end else begin
          chk($sformatf("hold_nodone_c%0d", c), done0, 0);
        end
        if (done0) ndone++;
      end
      hv[c] = 16'($urandom);
      hg[c] = (c % 2 == 0) ? 16'sd128 : 16'($urandom_range(300, 0));
      V = hv[c]; gate = hg[c];
      start0 = (c < 24);
    end
    chk("hold_done_count", ndone, 4);
    start0 = 1'b0;

    // Load a nonzero result, then abort mid-POW with an asynchronous reset.
    run(1'b0, tbl[0].v, tbl[0].g, lat, bc, res);
    @(negedge clk);
    V = tbl[1].v; gate = tbl[1].g; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy0, 0);
    chk("async_rst_done", done0, 0);
    chk("async_rst_I", I0, 0);
    ndone = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    chk("rst_I_still_0", I0, 0);
    run(1'b0, tbl[1].v, tbl[1].g, lat, bc, res);
    chk("post_rst_I", res, -4608);
    chk("post_rst_lat", lat, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
